// File: rtl/hq_pkg.sv
// Shared definitions for the complex coefficient-matrix MAC: default sizing,
// FSM state encoding and width helpers.
package hq_pkg;

    localparam int W_DEF    = 16;
    localparam int FRAC_DEF = 8;
    localparam int N_DEF    = 4;
    localparam int M_DEF    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Accumulator width: one W-bit product per row, plus headroom for N adds and sign.
    function automatic int acc_width(input int w, input int n);
        return w + $clog2(n) + 1;
    endfunction

    // Index width that never collapses to zero bits for a size of one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hq_cmat_mac_cmult.sv
// Registered complex multiplier: full 2W+1 precision product, arithmetic
// shift right by FRAC (floor), optional conjugation of the a operand.
module cmult_q #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int OW   = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_i,
    input  logic                 conj_i,
    input  logic [W-1:0]         a_r_i,
    input  logic [W-1:0]         a_i_i,
    input  logic [W-1:0]         b_r_i,
    input  logic [W-1:0]         b_i_i,
    output logic                 vld_o,
    output logic signed [OW-1:0] p_r_o,
    output logic signed [OW-1:0] p_i_o
);

    localparam int PW = 2 * W + 1;

    logic signed [PW-1:0] ar_s, ai_s, br_s, bi_s;
    logic signed [PW-1:0] rr_s, ii_s, ri_s, ir_s;
    logic signed [PW-1:0] re_s, im_s;

    assign ar_s = {{(W+1){a_r_i[W-1]}}, a_r_i};
    assign ai_s = {{(W+1){a_i_i[W-1]}}, a_i_i};
    assign br_s = {{(W+1){b_r_i[W-1]}}, b_r_i};
    assign bi_s = {{(W+1){b_i_i[W-1]}}, b_i_i};

    assign rr_s = ar_s * br_s;
    assign ii_s = ai_s * bi_s;
    assign ri_s = ar_s * bi_s;
    assign ir_s = ai_s * br_s;

    // Combine partial products; conjugating a flips the sign of its imaginary part.
    always_comb begin
        re_s = '0;
        im_s = '0;
        if (conj_i) begin
            re_s = rr_s + ii_s;
            im_s = ri_s - ir_s;
        end else begin
            re_s = rr_s - ii_s;
            im_s = ri_s + ir_s;
        end
    end

    // Mult stage register: scaled product and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_o <= 1'b0;
            p_r_o <= '0;
            p_i_o <= '0;
        end else begin
            vld_o <= vld_i;
            if (vld_i) begin
                p_r_o <= OW'(re_s >>> FRAC);
                p_i_o <= OW'(im_s >>> FRAC);
            end else begin
                p_r_o <= p_r_o;
                p_i_o <= p_i_o;
            end
        end
    end

endmodule

// File: rtl/hq_cmat_mac.sv
// Complex vector-by-matrix MAC: y[m] = sum_k h[k]*A[k][m], one product per
// cycle, per-column accumulators, saturated registered outputs.
module hq_cmat_mac
    import hq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int N    = N_DEF,
    parameter int M    = M_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     conj_en,
    input  logic [N*W-1:0]           h_r,
    input  logic [N*W-1:0]           h_i,
    input  logic                     coef_we,
    input  logic [$clog2(N*M)-1:0]   coef_addr,
    input  logic [W-1:0]             coef_r,
    input  logic [W-1:0]             coef_i,
    output logic [M*W-1:0]           out_r,
    output logic [M*W-1:0]           out_i,
    output logic                     busy,
    output logic                     out_valid,
    output logic                     sat
);

    localparam int AW    = $clog2(N*M);
    localparam int KW    = idx_width(N);
    localparam int MW    = idx_width(M);
    localparam int ACC_W = acc_width(W, N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N*M-1);
    localparam logic [KW-1:0] LAST_K   = KW'(N-1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_e              state_q;
    logic                busy_q, out_valid_q, sat_q, drain_q, conj_q;
    logic [M*W-1:0]      out_r_q, out_i_q, out_r_d, out_i_d;
    logic                sat_any_d;
    logic [N*W-1:0]      h_r_q, h_i_q;
    logic [AW-1:0]       idx_q;
    logic [KW-1:0]       k_q, tag_k_q;
    logic [MW-1:0]       m_q, tag_m_q;
    logic [W-1:0]        coef_r_q [N*M];
    logic [W-1:0]        coef_i_q [N*M];
    logic                pend_q;
    logic [AW-1:0]       pend_addr_q;
    logic [W-1:0]        pend_r_q, pend_i_q;
    logic signed [ACC_W-1:0] acc_r_q [M];
    logic signed [ACC_W-1:0] acc_i_q [M];

    logic                    start_acc_s, coef_ok_s, finish_s, iss_vld_s, p_vld_s;
    logic signed [ACC_W-1:0] p_r_s, p_i_s;

    assign start_acc_s = start && (state_q == ST_IDLE) && !busy_q;
    assign coef_ok_s   = coef_we && !busy_q;
    assign finish_s    = (state_q == ST_DRAIN) && drain_q;
    assign iss_vld_s   = (state_q == ST_RUN);

    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;

    cmult_q #(
        .W    (W),
        .FRAC (FRAC),
        .OW   (ACC_W)
    ) u_cmult (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (iss_vld_s),
        .conj_i (conj_q),
        .a_r_i  (h_r_q[k_q*W +: W]),
        .a_i_i  (h_i_q[k_q*W +: W]),
        .b_r_i  (coef_r_q[idx_q]),
        .b_i_i  (coef_i_q[idx_q]),
        .vld_o  (p_vld_s),
        .p_r_o  (p_r_s),
        .p_i_o  (p_i_s)
    );

    // Coefficient RAM; a write coinciding with start is parked until the run ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N*M; i++) begin
                coef_r_q[i] <= '0;
                coef_i_q[i] <= '0;
            end
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_r_q    <= '0;
            pend_i_q    <= '0;
        end else if (coef_ok_s && start_acc_s) begin
            pend_q      <= 1'b1;
            pend_addr_q <= coef_addr;
            pend_r_q    <= coef_r;
            pend_i_q    <= coef_i;
        end else if (coef_ok_s) begin
            coef_r_q[coef_addr] <= coef_r;
            coef_i_q[coef_addr] <= coef_i;
        end else if (finish_s && pend_q) begin
            coef_r_q[pend_addr_q] <= pend_r_q;
            coef_i_q[pend_addr_q] <= pend_i_q;
            pend_q                <= 1'b0;
        end else begin
            pend_q <= pend_q;
        end
    end

    // Tags follow each issued product into the mult stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_k_q <= '0;
            tag_m_q <= '0;
        end else if (iss_vld_s) begin
            tag_k_q <= k_q;
            tag_m_q <= m_q;
        end else begin
            tag_k_q <= tag_k_q;
            tag_m_q <= tag_m_q;
        end
    end

    // Column accumulators: restart on k=0, otherwise add the registered product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                acc_r_q[i] <= '0;
                acc_i_q[i] <= '0;
            end
        end else if (p_vld_s) begin
            if (tag_k_q == KW'(0)) begin
                acc_r_q[tag_m_q] <= p_r_s;
                acc_i_q[tag_m_q] <= p_i_s;
            end else begin
                acc_r_q[tag_m_q] <= acc_r_q[tag_m_q] + p_r_s;
                acc_i_q[tag_m_q] <= acc_i_q[tag_m_q] + p_i_s;
            end
        end
    end

    // Clamp every finished column sum to the W-bit range and flag any clamp.
    always_comb begin
        out_r_d   = '0;
        out_i_d   = '0;
        sat_any_d = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (acc_r_q[i] > SAT_MAX) begin
                out_r_d[i*W +: W] = SAT_MAX[W-1:0];
                sat_any_d         = 1'b1;
            end else if (acc_r_q[i] < SAT_MIN) begin
                out_r_d[i*W +: W] = SAT_MIN[W-1:0];
                sat_any_d         = 1'b1;
            end else begin
                out_r_d[i*W +: W] = acc_r_q[i][W-1:0];
            end
            if (acc_i_q[i] > SAT_MAX) begin
                out_i_d[i*W +: W] = SAT_MAX[W-1:0];
                sat_any_d         = 1'b1;
            end else if (acc_i_q[i] < SAT_MIN) begin
                out_i_d[i*W +: W] = SAT_MIN[W-1:0];
                sat_any_d         = 1'b1;
            end else begin
                out_i_d[i*W +: W] = acc_i_q[i][W-1:0];
            end
        end
    end

    // Run control FSM with registered busy/out_valid/sat and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            drain_q     <= 1'b0;
            conj_q      <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            h_r_q       <= '0;
            h_i_q       <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            m_q         <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        sat_q   <= 1'b0;
                        h_r_q   <= h_r;
                        h_i_q   <= h_i;
                        conj_q  <= conj_en;
                        idx_q   <= '0;
                        k_q     <= '0;
                        m_q     <= '0;
                    end else if (out_valid_q) begin
                        busy_q <= 1'b0;
                    end else begin
                        busy_q <= busy_q;
                    end
                end
                ST_RUN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                        if (k_q == LAST_K) begin
                            k_q <= '0;
                            m_q <= m_q + MW'(1);
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // First drain cycle lets the last product land in its accumulator.
                    if (drain_q) begin
                        state_q     <= ST_IDLE;
                        drain_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_r_q     <= out_r_d;
                        out_i_q     <= out_i_d;
                        sat_q       <= sat_any_d;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hq_cmat_mac.sv
// Scoreboard bench for hq_cmat_mac (W16/F8/N4/M2) with directed vectors.
module tb_hq_cmat_mac;

    logic        clk = 1'b0;
    logic        rst, start, conj_en, coef_we;
    logic [63:0] h_r, h_i;
    logic [2:0]  coef_addr;
    logic [15:0] coef_r, coef_i;
    logic [31:0] out_r, out_i;
    logic        busy, out_valid, sat;

    hq_cmat_mac #(.W(16), .FRAC(8), .N(4), .M(2)) dut (
        .clk(clk), .rst(rst), .start(start), .conj_en(conj_en),
        .h_r(h_r), .h_i(h_i), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_r(coef_r), .coef_i(coef_i), .out_r(out_r), .out_i(out_i),
        .busy(busy), .out_valid(out_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] r;
        logic [31:0] i;
        logic        s;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   nvalid  = 0;
    int   base_nv = 0;

    localparam logic [63:0] BH_R = {16'h0300, 16'h0300, 16'h0100, 16'h0200};
    localparam logic [63:0] BH_I = {16'h0300, 16'h0300, 16'h0000, 16'h0100};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every out_valid pops one expected result.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t e;
            nvalid++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got out_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("out_r", out_r, e.r);
                chk("out_i", out_i, e.i);
                chk("sat", {31'd0, sat}, {31'd0, e.s});
                chk("latency", cyc, e.c);
                chk("busy_at_valid", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic write_coef(input logic [2:0] a, input logic [15:0] r, input logic [15:0] i);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_r    = r;
        coef_i    = i;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic load_basic();
        for (int a = 0; a < 8; a++) write_coef(3'(a), 16'h0000, 16'h0000);
        write_coef(3'd0, 16'h0100, 16'h0000);
        write_coef(3'd5, 16'hFF00, 16'h0000);
    endtask

    task automatic start_run(input logic [63:0] hr, input logic [63:0] hi, input logic cj,
                             input logic push, input logic [31:0] er, input logic [31:0] ei,
                             input logic es, input logic we, input logic [2:0] wa,
                             input logic [15:0] wr, input logic [15:0] wi);
        @(negedge clk);
        base_nv   = nvalid;
        h_r       = hr;
        h_i       = hi;
        conj_en   = cj;
        start     = 1'b1;
        coef_we   = we;
        coef_addr = wa;
        coef_r    = wr;
        coef_i    = wi;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{r: er, i: ei, s: es, c: cyc + 10});
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start   = 1'b0;
        coef_we = 1'b0;
        h_r     = ~hr;
        h_i     = ~hi;
        conj_en = ~cj;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30 && nvalid == base_nv; i++) @(posedge clk);
        chk("run_completed", {31'd0, (nvalid != base_nv)}, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; conj_en = 1'b0; coef_we = 1'b0;
        h_r = '0; h_i = '0; coef_addr = '0; coef_r = '0; coef_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_r", out_r, 32'h0);
        chk("rst_out_i", out_i, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic run
        load_basic();
        start_run(BH_R, BH_I, 1'b0, 1'b1, 32'hFF00_0200, 32'h0000_0100, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done();

        // Same-cycle start + coef_we: run sees old A[0][0], next run sees new one
        start_run(BH_R, BH_I, 1'b0, 1'b1, 32'hFF00_0200, 32'h0000_0100, 1'b0, 1'b1, 3'd0, 16'h0200, 16'h0000);
        wait_done();
        start_run(BH_R, BH_I, 1'b0, 1'b1, 32'hFF00_0400, 32'h0000_0200, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done();
        write_coef(3'd0, 16'h0100, 16'h0000);

        // Protected operands: start and coef_we mid-run are ignored
        start_run(BH_R, BH_I, 1'b0, 1'b1, 32'hFF00_0200, 32'h0000_0100, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        start = 1'b1; h_r = {4{16'h7000}}; coef_we = 1'b1; coef_addr = 3'd0;
        coef_r = 16'h0500; coef_i = 16'h0500;
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0;
        wait_done();
        start_run(BH_R, BH_I, 1'b0, 1'b1, 32'hFF00_0200, 32'h0000_0100, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done();

        // Saturation
        for (int a = 0; a < 8; a++) write_coef(3'(a), 16'h0100, 16'h0000);
        start_run({4{16'h7000}}, 64'h0, 1'b0, 1'b1, 32'h7FFF_7FFF, 32'h0000_0000, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done();

        // Reset while idle clears outputs and sat
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_rst_out_r", out_r, 32'h0);
        chk("idle_rst_out_i", out_i, 32'h0);
        chk("idle_rst_busy", {31'd0, busy}, 32'd0);
        chk("idle_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_rst_sat", {31'd0, sat}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Coefficient RAM is zero after reset
        start_run(BH_R, BH_I, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done();

        // Conjugate mode
        write_coef(3'd0, 16'h0100, 16'h0000);
        start_run({16'h0300, 16'h0300, 16'h0300, 16'h0000}, {16'h0200, 16'h0200, 16'h0200, 16'h0100},
                  1'b1, 1'b1, 32'h0000_0000, 32'h0000_FF00, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done();

        // Reset mid-run aborts without out_valid
        start_run(BH_R, BH_I, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrun_rst_out_i", out_i, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        load_basic();
        start_run(BH_R, BH_I, 1'b0, 1'b1, 32'hFF00_0200, 32'h0000_0100, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hq_cmat_mac.md
HQ_CMAT_MAC -- requirements
Module: hq_cmat_mac

Interface
REQ-001 SHALL have parameter W, default 16, meaning the signed fixed-point width of each real/imag component.
REQ-002 SHALL have parameter FRAC, default 8, meaning the fractional bits (Q(W-FRAC).FRAC).
REQ-003 SHALL have parameter N, default 4, meaning the H vector length and coefficient matrix row count.
REQ-004 SHALL have parameter M, default 2, meaning the coefficient column count and output count.
REQ-005 SHALL have ports: clk  in  1  single clock; rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: start  in  1  run request; conj_en  in  1  multiply by conj(h[k]) when 1.
REQ-007 SHALL have ports: h_r, h_i  in  N*W each  h[k] at bits [k*W +: W].
REQ-008 SHALL have ports: coef_we  in  1; coef_addr  in  clog2(N*M)  index m*N+k; coef_r, coef_i  in  W each.
REQ-009 SHALL have ports: out_r, out_i  out  M*W each  y[m] at [m*W +: W]; busy  out  1; out_valid  out  1; sat  out  1.

Function
REQ-010 SHALL compute y[m] = sum over k=0..N-1 of h[k]*A[k][m] (h[k] conjugated if conj_en), for m=0..M-1.
REQ-011 SHALL use an FSM with states IDLE, RUN, DRAIN: IDLE->RUN on start; RUN->DRAIN after N*M issue cycles; DRAIN->IDLE after the pipeline empties.
REQ-012 SHALL accept start only in IDLE, latching h_r, h_i and conj_en on the accepting edge.
REQ-013 SHALL ignore start while busy=1; a second start SHALL NOT restart the run or alter the latched operands.
REQ-014 SHALL issue one complex product per RUN cycle in the order m outer, k inner.
REQ-015 SHALL register each product in one cycle (mult stage), then add it into the column accumulator on the following edge.
REQ-016 SHALL form each product at full 2W precision, then arithmetic-shift right by FRAC (truncation toward -inf).
REQ-017 SHALL accumulate at width W+clog2(N)+1 and clear the accumulator at k=0 of each column.
REQ-018 SHALL saturate each finished column sum to [-2^(W-1), 2^(W-1)-1] per component when writing it to out_r/out_i.
REQ-019 SHALL make sat equal to the OR of all saturation events in the run; sat is valid with out_valid and held until the next accepted start.
REQ-020 SHALL pulse out_valid for exactly one cycle, N*M+2 cycles after the start-accepting edge.
REQ-021 SHALL drive busy=1 from the edge after start acceptance up to and including the out_valid cycle.
REQ-022 SHALL hold out_r/out_i stable from out_valid until the next run's out_valid, and SHALL NOT update them mid-run.
REQ-023 SHALL write coefficient RAM A[k][m] on a coef_we edge while busy=0.
REQ-024 SHALL drop coef_we while busy=1, so that coefficients stay constant for the whole run.
REQ-025 SHALL give start precedence over a same-cycle coef_we in IDLE: the write lands, but the run uses the pre-write value of that entry.

Reset
REQ-026 SHALL, on asserted rst (async) and regardless of state, force state=IDLE, busy=0, out_valid=0, sat=0, out_r=out_i=0, and clear counters, accumulators and the mult stage.
REQ-027 SHALL clear all coefficient RAM entries to 0 on rst.
REQ-028 SHALL abort a run interrupted by rst with no out_valid; the first start after release SHALL behave as from power-up.

Structure
REQ-029 SHALL take the FSM state encoding, the default W/FRAC/N/M values and the accumulator-width function from shared package hq_pkg.
REQ-030 SHALL instantiate one sub-module, cmult_q (registered complex multiply, W-bit in, FRAC shift, conj option), once.

Verification
REQ-031 SHALL cover reset: assert rst mid-idle -> out_r=out_i=0, busy=0, out_valid=0, sat=0.
REQ-032 SHALL cover basic run (W16/F8/N4/M2): A[0][0]=0x0100, A[1][1]=0xFF00, others 0; h[0]=(0x0200,0x0100), h[1]=(0x0100,0), h[2]=h[3]=(0x0300,0x0300) -> out_valid at +10 cycles, y0=(0x0200,0x0100), y1=(0xFF00,0x0000), sat=0.
REQ-033 SHALL cover saturation: all A=(0x0100,0), all h=(0x7000,0) -> y0=y1=(0x7FFF,0x0000), sat=1.
REQ-034 SHALL cover conjugate mode: conj_en=1, h[0]=(0,0x0100), A[0][0]=(0x0100,0), others 0 -> y0=(0x0000,0xFF00).
REQ-035 SHALL cover protected operands: start and coef_we pulsed at cycle 4 of a run -> single out_valid at +10 with results unchanged; the coefficient write is absent on readback by the next run.
REQ-036 SHALL cover reset mid-run: rst at cycle 5 of a run -> no out_valid, busy=0 next cycle; a later run gives the REQ-032 results after the coefficients are reloaded.
